uctl_rst_seq: RTL and testbench

//  Reset sequencer for the USB controller. Holds all sub-block resets low after power-on
//  or a soft/bus reset request, then releases them one stage at a time in a fixed order
//  (e.g. PHY i/f, protocol engine, DMA, register file), with programmable gaps between

---
 rtl/uctl_rst_pkg.sv | 25 ++
 rtl/uctl_rst_tmr.sv | 30 +++
 rtl/uctl_rst_seq.sv | 163 ++++++++++++++++
 tb/tb_uctl_rst_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uctl_rst_pkg.sv
// Shared types and constants for the USB controller reset sequencer:
// FSM state encoding, reset-cause codes and default timing values.
package uctl_rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REL  = 2'd1,
        ST_DONE = 2'd2
    } rst_state_t;

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_BUS = 2'b11;

    localparam int NUM_STG_DEF  = 4;
    localparam int HOLD_CYC_DEF = 16;
    localparam int GAP_CYC_DEF  = 8;
    localparam int CNT_W_DEF    = 8;

    // Stage index width; a single-stage sequencer still needs a 1-bit index.
    function automatic int stg_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uctl_rst_tmr.sv
// Hold/gap timer for the reset sequencer: CNT_W up-counter with synchronous
// clear, count enable and a terminal-count flag at lim-1.
module uctl_rst_tmr
    import uctl_rst_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             uctl_PoRst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] lim,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge uctl_PoRst_n) begin
        if (!uctl_PoRst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == (lim - CNT_W'(1)));

endmodule

// File: rtl/uctl_rst_seq.sv
// USB controller reset sequencer: holds all sub-block resets, then releases them
// one stage at a time. Optional rst_cause port is enabled by UCTL_RST_CAUSE_EN.
module uctl_rst_seq
    import uctl_rst_pkg::*;
#(
    parameter int NUM_STG  = NUM_STG_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               uctl_PoRst_n,
    input  logic               sw_rst_req,
    input  logic               bus_rst_req,
    output logic [NUM_STG-1:0] rst_n_o,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               rst_ack
`ifdef UCTL_RST_CAUSE_EN
    ,
    output logic [1:0]         rst_cause
`endif
);

    localparam int SW = stg_idx_w(NUM_STG);

    rst_state_t         state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [NUM_STG-1:0] rst_n_q, rst_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;
    logic               req_q;
    logic               req;
    logic               tmr_clr;
    logic               tmr_en;
    logic [CNT_W-1:0]   tmr_lim;
    logic               tmr_tc;
`ifdef UCTL_RST_CAUSE_EN
    logic [1:0]         cause_q, cause_d;
`endif

    assign req = sw_rst_req | bus_rst_req;

    uctl_rst_tmr #(
        .CNT_W (CNT_W)
    ) u_tmr (
        .clk          (clk),
        .uctl_PoRst_n (uctl_PoRst_n),
        .clr          (tmr_clr),
        .en           (tmr_en),
        .lim          (tmr_lim),
        .tc           (tmr_tc)
    );

    always_ff @(posedge clk or negedge uctl_PoRst_n) begin
        if (!uctl_PoRst_n) begin
            state_q <= ST_HOLD;
            stage_q <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
`ifdef UCTL_RST_CAUSE_EN
            cause_q <= CAUSE_POR;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            rst_n_q <= rst_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            req_q   <= req;
`ifdef UCTL_RST_CAUSE_EN
            cause_q <= cause_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        rst_n_d = rst_n_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ack_d   = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        tmr_lim = CNT_W'(HOLD_CYC);
`ifdef UCTL_RST_CAUSE_EN
        cause_d = cause_q;
`endif

        // A request pins the timer at zero, so the hold restarts once it drops.
        if (req) begin
            state_d = ST_HOLD;
            stage_d = '0;
            rst_n_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            ack_d   = ~req_q;
            tmr_clr = 1'b1;
`ifdef UCTL_RST_CAUSE_EN
            cause_d = bus_rst_req ? CAUSE_BUS : CAUSE_SW;
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    tmr_en  = 1'b1;
                    tmr_lim = CNT_W'(HOLD_CYC);
                    if (tmr_tc) begin
                        rst_n_d = NUM_STG'(1);
                        stage_d = '0;
                        tmr_clr = 1'b1;
                        if (NUM_STG == 1) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_REL;
                        end
                    end
                end
                ST_REL: begin
                    tmr_en  = 1'b1;
                    tmr_lim = CNT_W'(GAP_CYC);
                    if (tmr_tc) begin
                        // Shifting in a one keeps rst_n_o thermometer-coded.
                        stage_d = stage_q + SW'(1);
                        rst_n_d = (rst_n_q << 1) | NUM_STG'(1);
                        tmr_clr = 1'b1;
                        if (stage_d == SW'(NUM_STG - 1)) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    tmr_en = 1'b0;
                end
                default: begin
                    state_d = ST_HOLD;
                    rst_n_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    tmr_clr = 1'b1;
                end
            endcase
        end
    end

    assign rst_n_o  = rst_n_q;
    assign seq_busy = busy_q;
    assign seq_done = done_q;
    assign rst_ack  = ack_q;
`ifdef UCTL_RST_CAUSE_EN
    assign rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_uctl_rst_seq.sv
// Self-checking bench for uctl_rst_seq: directed scenarios plus random request
// traffic, compared each cycle against a count-of-quiet-cycles reference model.
module tb_uctl_rst_seq;

    localparam int NUM  = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 8;

    logic           clk;
    logic           por_n;
    logic           sw;
    logic           bus;
    logic [NUM-1:0] rst_n;
    logic           busy;
    logic           done;
    logic           ack;
`ifdef UCTL_RST_CAUSE_EN
    logic [1:0]     cause;
`endif

    int errs   = 0;
    int checks = 0;

    // Reference model state
    int         quiet;
    bit         prev_req;
    bit         ack_m;
    logic [1:0] cause_m;
    int         ack_seen;

    uctl_rst_seq #(
        .NUM_STG  (NUM),
        .HOLD_CYC (HOLD),
        .GAP_CYC  (GAP),
        .CNT_W    (8)
    ) dut (
        .clk          (clk),
        .uctl_PoRst_n (por_n),
        .sw_rst_req   (sw),
        .bus_rst_req  (bus),
        .rst_n_o      (rst_n),
        .seq_busy     (busy),
        .seq_done     (done),
        .rst_ack      (ack)
`ifdef UCTL_RST_CAUSE_EN
        ,
        .rst_cause    (cause)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Released stage count follows from how long the request has been quiet.
    function automatic int exp_stages(input int q);
        int n;
        if (q < HOLD) return 0;
        n = 1 + (q - HOLD) / GAP;
        return (n > NUM) ? NUM : n;
    endfunction

    function automatic logic [NUM-1:0] exp_rst(input int q);
        return NUM'((1 << exp_stages(q)) - 1);
    endfunction

    task automatic model_por();
        quiet    = 0;
        prev_req = 1'b0;
        ack_m    = 1'b0;
        cause_m  = 2'b01;
    endtask

    task automatic compare(input string tag);
        chk({tag, ".rst_n"}, 32'(rst_n), 32'(exp_rst(quiet)));
        chk({tag, ".done"},  32'(done),  32'(exp_stages(quiet) == NUM));
        chk({tag, ".busy"},  32'(busy),  32'(exp_stages(quiet) != NUM));
        chk({tag, ".ack"},   32'(ack),   32'(ack_m));
`ifdef UCTL_RST_CAUSE_EN
        chk({tag, ".cause"}, 32'(cause), 32'(cause_m));
`endif
    endtask

    task automatic step();
        bit req;
        @(posedge clk);
        req   = sw | bus;
        ack_m = req & ~prev_req;
        if (req) begin
            quiet   = 0;
            cause_m = bus ? 2'b11 : 2'b10;
        end else if (quiet < 100000) begin
            quiet++;
        end
        prev_req = req;
        #1;
        if (ack === 1'b1) ack_seen++;
        compare("cyc");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert POR between edges, confirm the asynchronous clear, release on negedge.
    task automatic por_pulse();
        #2 por_n = 1'b0;
        #1;
        model_por();
        chk("por.rst_n", 32'(rst_n), 32'h0);
        chk("por.busy",  32'(busy),  32'h1);
        chk("por.done",  32'(done),  32'h0);
        chk("por.ack",   32'(ack),   32'h0);
`ifdef UCTL_RST_CAUSE_EN
        chk("por.cause", 32'(cause), 32'h1);
`endif
        @(negedge clk);
        por_n = 1'b1;
    endtask

    task automatic pulse(input bit s, input bit b);
        sw  = s;
        bus = b;
        step();
        sw  = 1'b0;
        bus = 1'b0;
    endtask

    initial begin
        por_n    = 1'b0;
        sw       = 1'b0;
        bus      = 1'b0;
        ack_seen = 0;
        model_por();
        repeat (3) @(negedge clk);
        compare("reset");
        por_n = 1'b1;

        // POR release timing
        run(15); chk("t1.e15", 32'(rst_n), 32'h0);
        run(1);  chk("t1.e16", 32'(rst_n), 32'h1);
        run(8);  chk("t1.e24", 32'(rst_n), 32'h3);
        run(8);  chk("t1.e32", 32'(rst_n), 32'h7);
        run(7);  chk("t1.e39", 32'(done),  32'h0);
        run(1);  chk("t1.e40", 32'(rst_n), 32'hF);
        chk("t1.done", 32'(done), 32'h1);
        chk("t1.busy", 32'(busy), 32'h0);

        // Soft reset pulse from idle
        run(5);
        pulse(1'b1, 1'b0);
        chk("t2.rst_n", 32'(rst_n), 32'h0);
        chk("t2.ack",   32'(ack),   32'h1);
        run(1);  chk("t2.ack_off", 32'(ack), 32'h0);
        run(14); chk("t2.e15", 32'(rst_n), 32'h0);
        run(1);  chk("t2.e16", 32'(rst_n), 32'h1);

        // Bus reset while partially released
        run(8);  chk("t3.pre", 32'(rst_n), 32'h3);
        pulse(1'b0, 1'b1);
        chk("t3.rst_n", 32'(rst_n), 32'h0);
        run(15); chk("t3.e15", 32'(rst_n), 32'h0);
        run(1);  chk("t3.e16", 32'(rst_n), 32'h1);
        run(24); chk("t3.e40", 32'(rst_n), 32'hF);

        // Soft reset held for 50 cycles
        ack_seen = 0;
        sw = 1'b1;
        run(50);
        chk("t4.held", 32'(rst_n), 32'h0);
        sw = 1'b0;
        chk("t4.acks", 32'(ack_seen), 32'd1);
        run(15); chk("t4.e15", 32'(rst_n), 32'h0);
        run(1);  chk("t4.e16", 32'(rst_n), 32'h1);
        run(24);

        // Simultaneous requests
        ack_seen = 0;
        pulse(1'b1, 1'b1);
        run(3);
        chk("t5.acks", 32'(ack_seen), 32'd1);
        run(40);

        // POR mid-release
        pulse(1'b1, 1'b0);
        run(32); chk("t6.pre", 32'(rst_n), 32'h7);
        por_pulse();
        run(16); chk("t6.e16", 32'(rst_n), 32'h1);
        run(24); chk("t6.e40", 32'(rst_n), 32'hF);

        // Random request traffic
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: run($urandom_range(1, 50));
                6: begin sw = 1'b1; run($urandom_range(1, 3)); end
                7: begin bus = 1'b1; run($urandom_range(1, 3)); end
                8: begin sw = 1'b1; bus = 1'b1; run($urandom_range(1, 3)); end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        por_pulse();
                    end else begin
                        sw  = 1'($urandom_range(0, 1));
                        bus = 1'($urandom_range(0, 1));
                        run(1);
                    end
                end
            endcase
            sw  = 1'b0;
            bus = 1'b0;
        end
        run(HOLD + NUM * GAP);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
